// File: rtl/main_reg_file.sv
// main_reg_file
//   Eight-entry register file with two registered read ports and a small
//   write queue in front of the storage array. Accepted writes are queued and
//   drained into the array one per cycle. Reads see the newest value, taken
//   first from the write being accepted, then the queue, then the array.
//   Register 0 always reads as zero.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rd_en      read request, sampled on the rising edge
//   rd_adrs_a  read port A address
//   rd_adrs_b  read port B address
//   rd_data_a  registered read data, port A
//   rd_data_b  registered read data, port B
//   rd_valid   one-cycle strobe marking fresh read data
//   wr_valid   write request valid
//   wr_ready   write queue has a free slot
//   wr_adrs    write address
//   wr_data    write data
//   q_count    number of queued writes
module main_reg_file #(
  parameter  int DATA_W = 16,
  parameter  int ADRS_W = 3,
  parameter  int QDEPTH = 2,
  localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADRS_W-1:0] rd_adrs_a,
  input  logic [ADRS_W-1:0] rd_adrs_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADRS_W-1:0] wr_adrs,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  q_count
);

  localparam int               NREG  = 1 << ADRS_W;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [DATA_W-1:0] regs     [NREG];
  logic [ADRS_W-1:0] q_adrs   [QDEPTH];
  logic [DATA_W-1:0] q_data   [QDEPTH];
  logic [ADRS_W-1:0] q_adrs_nxt [QDEPTH];
  logic [DATA_W-1:0] q_data_nxt [QDEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Queue entry 0 is the head (oldest); higher indices are newer.
  assign wr_ready = (cnt < QFULL);
  assign accept   = wr_valid && wr_ready;
  assign drain    = (cnt != '0);
  assign q_count  = cnt;

  // Newest value visible for address a at this edge. Later matches override
  // earlier ones, so the newest queue entry wins, and the write being
  // accepted right now beats everything queued.
  function automatic logic [DATA_W-1:0] lookup(input logic [ADRS_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
    for (int i = 0; i < QDEPTH; i++) begin
      if ((i < int'(cnt)) && (q_adrs[i] == a)) v = q_data[i];
    end
    if (accept && (wr_adrs == a)) v = wr_data;
    if (a == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    fwd_a = lookup(rd_adrs_a);
    fwd_b = lookup(rd_adrs_b);
  end

  // Next queue contents: pop the head when non-empty, then append the
  // accepted write behind whatever remains.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      q_adrs_nxt[i] = q_adrs[i];
      q_data_nxt[i] = q_data[i];
    end
    cnt_nxt = cnt;
    if (drain) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        q_adrs_nxt[i] = q_adrs[i+1];
        q_data_nxt[i] = q_data[i+1];
      end
      cnt_nxt = cnt - ONE;
    end
    if (accept) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (i == int'(cnt_nxt)) begin
          q_adrs_nxt[i] = wr_adrs;
          q_data_nxt[i] = wr_data;
        end
      end
      cnt_nxt = cnt_nxt + ONE;
    end
  end

  // Registered state: storage, queue, read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_adrs[i] <= '0;
        q_data[i] <= '0;
      end
      cnt       <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_adrs[i] <= q_adrs_nxt[i];
        q_data[i] <= q_data_nxt[i];
      end
      cnt <= cnt_nxt;
      // Writes to register 0 are drained but never stored.
      if (drain && (q_adrs[0] != '0)) regs[q_adrs[0]] <= q_data[0];
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= fwd_a;
        rd_data_b <= fwd_b;
      end
    end
  end

endmodule

// File: tb/tb_main_reg_file.sv
module tb_main_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [2:0]  rd_adrs_a, rd_adrs_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_adrs;
  logic [15:0] wr_data;
  logic [1:0]  q_count;

  main_reg_file #(.DATA_W(16), .ADRS_W(3), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .rd_adrs_a(rd_adrs_a), .rd_adrs_b(rd_adrs_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_adrs(wr_adrs),
    .wr_data(wr_data), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] a; logic [15:0] d; } ent_t;

  // Reference model: pending writes as a FIFO list, storage as an array.
  ent_t        mq[$];
  logic [15:0] marr [8];
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic [15:0] cur_a = '0, cur_b = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a read of address a returns, given the write offered this edge.
  function automatic logic [15:0] mread(input logic [2:0] a, input bit acc,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0000;
    if (acc && wa == a) return wd;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == a) return mq[i].d;
    return marr[a];
  endfunction

  // One clock: drive at the falling edge, update the model at the rising edge.
  task automatic cycle(input bit wv, input logic [2:0] wa, input logic [15:0] wd,
                       input bit re, input logic [2:0] ra, input logic [2:0] rb,
                       output bit acc);
    ent_t e;
    wr_valid = wv; wr_adrs = wa; wr_data = wd;
    rd_en = re; rd_adrs_a = ra; rd_adrs_b = rb;
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() < 2));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    acc = wv && (mq.size() < 2);
    if (re) begin
      sb_a.push_back(mread(ra, acc, wa, wd));
      sb_b.push_back(mread(rb, acc, wa, wd));
    end
    @(posedge clk);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      marr[e.a] = e.d;
    end
    if (acc) begin
      e.a = wa; e.d = wd;
      mq.push_back(e);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_en = 1'b0;
    mq.delete(); sb_a.delete(); sb_b.delete();
    for (int i = 0; i < 8; i++) marr[i] = '0;
    #1;
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data_a", 32'(rd_data_a), 32'd0);
    chk("rst_rd_data_b", 32'(rd_data_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT flags fresh read data and
  // otherwise checks that the read outputs hold.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cur_a = '0; cur_b = '0;
    end else begin
      chk("rd_valid", 32'(rd_valid), 32'(sb_a.size() > 0));
      if (rd_valid && sb_a.size() > 0) begin
        cur_a = sb_a.pop_front();
        cur_b = sb_b.pop_front();
      end
      chk("rd_data_a", 32'(rd_data_a), 32'(cur_a));
      chk("rd_data_b", 32'(rd_data_b), 32'(cur_b));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [2:0]  seq_a [4];
    logic [15:0] seq_d [4];
    rst_n = 1'b0; rd_en = 1'b0; wr_valid = 1'b0;
    rd_adrs_a = '0; rd_adrs_b = '0; wr_adrs = '0; wr_data = '0;
    @(negedge clk);
    do_reset();

    // Write r3, idle, read A=3 B=0.
    cycle(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, acc);
    idle(2);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0, acc);
    chk("r3_read_a", 32'(rd_data_a), 32'h1234);
    chk("r0_read_b", 32'(rd_data_b), 32'h0000);
    chk("rd_valid_drop", 32'(rd_valid), 32'd1);
    idle(1);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);

    // Same-edge forwarding.
    cycle(1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd5, 3'd5, acc);
    chk("fwd_r5_a", 32'(rd_data_a), 32'hBEEF);
    chk("fwd_r5_b", 32'(rd_data_b), 32'hBEEF);

    // Four writes with wr_valid held until each is accepted.
    seq_a[0] = 3'd1; seq_d[0] = 16'h0001;
    seq_a[1] = 3'd1; seq_d[1] = 16'h0002;
    seq_a[2] = 3'd2; seq_d[2] = 16'h0003;
    seq_a[3] = 3'd2; seq_d[3] = 16'h0004;
    for (int k = 0; k < 4; k++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) cycle(1'b1, seq_a[k], seq_d[k], 1'b0, 3'd0, 3'd0, acc);
      chk("burst_accept", 32'(acc), 32'd1);
      chk("burst_qcount_le2", 32'(q_count <= 2'd2), 32'd1);
    end
    idle(3);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd2, acc);
    chk("burst_r1", 32'(rd_data_a), 32'h0002);
    chk("burst_r2", 32'(rd_data_b), 32'h0004);

    // Back-to-back writes to r4, read while queued.
    cycle(1'b1, 3'd4, 16'hAAAA, 1'b0, 3'd0, 3'd0, acc);
    cycle(1'b1, 3'd4, 16'h5555, 1'b1, 3'd4, 3'd4, acc);
    chk("newest_r4", 32'(rd_data_a), 32'h5555);
    idle(3);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd0, acc);
    chk("drained_r4", 32'(rd_data_a), 32'h5555);

    // Write r0 and read it before and after drain.
    cycle(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, acc);
    chk("r0_before", 32'(rd_data_a), 32'h0000);
    idle(2);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, acc);
    chk("r0_after", 32'(rd_data_a), 32'h0000);

    // Queue writes to r6, reset before the drain.
    cycle(1'b1, 3'd6, 16'h1111, 1'b0, 3'd0, 3'd0, acc);
    cycle(1'b1, 3'd6, 16'h2222, 1'b0, 3'd0, 3'd0, acc);
    do_reset();
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd3, acc);
    chk("post_rst_r6", 32'(rd_data_a), 32'h0000);
    chk("post_rst_r3", 32'(rd_data_b), 32'h0000);

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if (n % 250 == 249) do_reset();
      cycle(($urandom % 4) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom % 2) == 1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), acc);
    end
    idle(3);
    chk("sb_empty", 32'(sb_a.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
